// File: rtl/aidc_lite_job_sched.sv
// Descriptor queue plus launch FSM feeding a single block-copy engine.
// Pops one {src, dst, len} job at a time, pulses start, and waits for the engine's done level.
module aidc_lite_job_sched #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [31:0]              push_src_addr_i,
  input  logic [31:0]              push_dst_addr_i,
  input  logic [24:0]              push_len_i,
  input  logic                     flush_i,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   pend_cnt_o,
  output logic [31:0]              eng_src_addr_o,
  output logic [31:0]              eng_dst_addr_o,
  output logic [24:0]              eng_len_o,
  output logic                     eng_start_o,
  input  logic                     eng_done_i,
  output logic                     busy_o,
  output logic [7:0]               done_cnt_o,
  output logic                     ovf_o,
  input  logic                     irq_en_i,
  input  logic                     irq_clr_i,
  output logic                     irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_ARM, S_WAIT_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      done_cnt_q, done_cnt_d;
  logic            ovf_q, ovf_d;
  logic            irq_q, irq_d;
  logic [31:0]     eng_src_q, eng_src_d;
  logic [31:0]     eng_dst_q, eng_dst_d;
  logic [24:0]     eng_len_q, eng_len_d;

  logic [31:0]     src_mem [DEPTH];
  logic [31:0]     dst_mem [DEPTH];
  logic [24:0]     len_mem [DEPTH];

  logic            full;
  logic            push_acc;
  logic            pop;
  logic            load;
  logic            complete;
  logic            start;
  logic [31:0]     head_src;
  logic [31:0]     head_dst;
  logic [24:0]     head_len;

  assign full     = (cnt_q == CW'(DEPTH));
  assign push_acc = push_i && !full && !flush_i;
  assign head_src = src_mem[rd_ptr_q];
  assign head_dst = dst_mem[rd_ptr_q];
  assign head_len = len_mem[rd_ptr_q];

  // Storage kept out of the reset block so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      src_mem[wr_ptr_q] <= push_src_addr_i;
      dst_mem[wr_ptr_q] <= push_dst_addr_i;
      len_mem[wr_ptr_q] <= push_len_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    load     = 1'b0;
    complete = 1'b0;
    start    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((cnt_q != '0) && eng_done_i && !flush_i) begin
          pop = 1'b1;
          if (head_len != '0) begin
            load    = 1'b1;
            state_d = S_LAUNCH;
          end else begin
            complete = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        start   = 1'b1;
        state_d = S_ARM;
      end
      S_ARM: begin
        if (!eng_done_i) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (eng_done_i) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_acc && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!push_acc && pop) cnt_d = cnt_q - CW'(1);
    end

    // Set conditions win over a same-cycle clear.
    done_cnt_d = complete ? done_cnt_q + 8'd1 : done_cnt_q;
    irq_d      = (complete && irq_en_i) ? 1'b1 : (irq_clr_i ? 1'b0 : irq_q);
    ovf_d      = (push_i && full) ? 1'b1 : (irq_clr_i ? 1'b0 : ovf_q);

    eng_src_d = load ? head_src : eng_src_q;
    eng_dst_d = load ? head_dst : eng_dst_q;
    eng_len_d = load ? head_len : eng_len_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      done_cnt_q <= '0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
      eng_src_q  <= '0;
      eng_dst_q  <= '0;
      eng_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      done_cnt_q <= done_cnt_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
      eng_src_q  <= eng_src_d;
      eng_dst_q  <= eng_dst_d;
      eng_len_q  <= eng_len_d;
    end
  end

  assign full_o         = full;
  assign pend_cnt_o     = cnt_q;
  assign eng_src_addr_o = eng_src_q;
  assign eng_dst_addr_o = eng_dst_q;
  assign eng_len_o      = eng_len_q;
  assign eng_start_o    = start;
  assign busy_o         = (state_q != S_IDLE);
  assign done_cnt_o     = done_cnt_q;
  assign ovf_o          = ovf_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_aidc_lite_job_sched.sv
// Scoreboarded bench for aidc_lite_job_sched with a simple behavioural copy engine.
module tb_aidc_lite_job_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_i;
  logic [31:0] push_src_addr_i;
  logic [31:0] push_dst_addr_i;
  logic [24:0] push_len_i;
  logic        flush_i;
  logic        full_o;
  logic [2:0]  pend_cnt_o;
  logic [31:0] eng_src_addr_o;
  logic [31:0] eng_dst_addr_o;
  logic [24:0] eng_len_o;
  logic        eng_start_o;
  logic        eng_done_i;
  logic        busy_o;
  logic [7:0]  done_cnt_o;
  logic        ovf_o;
  logic        irq_en_i;
  logic        irq_clr_i;
  logic        irq_o;

  logic        done_model = 1'b1;
  logic        force_busy = 1'b0;

  always #5 clk = ~clk;
  assign eng_done_i = done_model && !force_busy;

  aidc_lite_job_sched #(.DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .push_i          (push_i),
    .push_src_addr_i (push_src_addr_i),
    .push_dst_addr_i (push_dst_addr_i),
    .push_len_i      (push_len_i),
    .flush_i         (flush_i),
    .full_o          (full_o),
    .pend_cnt_o      (pend_cnt_o),
    .eng_src_addr_o  (eng_src_addr_o),
    .eng_dst_addr_o  (eng_dst_addr_o),
    .eng_len_o       (eng_len_o),
    .eng_start_o     (eng_start_o),
    .eng_done_i      (eng_done_i),
    .busy_o          (busy_o),
    .done_cnt_o      (done_cnt_o),
    .ovf_o           (ovf_o),
    .irq_en_i        (irq_en_i),
    .irq_clr_i       (irq_clr_i),
    .irq_o           (irq_o)
  );

  typedef struct {
    logic [31:0] s;
    logic [31:0] d;
    logic [24:0] l;
  } desc_t;

  desc_t exp_q[$];
  int    n_checks  = 0;
  int    n_err     = 0;
  int    n_starts  = 0;
  int    zl_cnt    = 0;
  int    done_base = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_done();
    int v;
    v = zl_cnt + n_starts - done_base;
    return v[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // acc tells whether this push should be accepted (queue not full).
  task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [24:0] l, input logic acc);
    desc_t e;
    push_i = 1'b1;
    push_src_addr_i = s;
    push_dst_addr_i = d;
    push_len_i = l;
    chk("full_before_push", full_o, !acc);
    if (acc) begin
      if (l != '0) begin
        e.s = s; e.d = d; e.l = l;
        exp_q.push_back(e);
      end else begin
        zl_cnt++;
      end
    end
    $display("push src=%08h dst=%08h len=%0d acc=%0d", s, d, l, acc);
    tick();
    push_i = 1'b0;
  endtask

  task automatic clr_irq();
    irq_clr_i = 1'b1;
    tick();
    irq_clr_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy_o && pend_cnt_o == '0 && eng_done_i) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({tag, "_idle_timeout"}, busy_o, 1'b0);
    tick();
  endtask

  task automatic wait_done_low(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!eng_done_i) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({tag, "_done_low_timeout"}, eng_done_i, 1'b0);
    tick();
  endtask

  // Engine model: done drops the cycle after start, stays low min(len,6) cycles.
  initial begin : engine
    int          left;
    logic        pend_start;
    logic        rst_seen;
    logic [24:0] plen;
    desc_t       e;
    left = 0;
    pend_start = 1'b0;
    plen = '0;
    forever begin
      @(negedge clk);
      rst_seen = rst;
      pend_start = 1'b0;
      if (eng_start_o && !rst) begin
        plen = eng_len_o;
        pend_start = 1'b1;
        n_starts++;
        $display("start src=%08h dst=%08h len=%0d", eng_src_addr_o, eng_dst_addr_o, eng_len_o);
        if (exp_q.size() == 0) begin
          chk("unexpected_start", eng_start_o, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("start_src", eng_src_addr_o, e.s);
          chk("start_dst", eng_dst_addr_o, e.d);
          chk("start_len", eng_len_o, e.l);
        end
      end
      @(posedge clk);
      #1;
      if (rst_seen) begin
        done_model = 1'b1;
        left = 0;
      end else if (pend_start) begin
        done_model = 1'b0;
        left = (plen > 25'd6) ? 6 : int'(plen);
      end else if (!done_model) begin
        if (left <= 1) done_model = 1'b1;
        else left--;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s_before;
    rst = 1'b1;
    push_i = 1'b0;
    push_src_addr_i = '0;
    push_dst_addr_i = '0;
    push_len_i = '0;
    flush_i = 1'b0;
    irq_en_i = 1'b1;
    irq_clr_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_busy", busy_o, 0);
    chk("rst_pend", pend_cnt_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_done_cnt", done_cnt_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_start", eng_start_o, 0);
    chk("rst_eng_src", eng_src_addr_o, 0);

    // Single job: launch latency, pulse width, held engine registers.
    push(32'h1000, 32'h8000, 25'd2, 1'b1);
    chk("lat_n1_start", eng_start_o, 0);
    tick();
    chk("lat_n2_start", eng_start_o, 1);
    chk("lat_n2_busy", busy_o, 1);
    tick();
    chk("pulse_width", eng_start_o, 0);
    chk("hold_src_run", eng_src_addr_o, 32'h1000);
    wait_idle("job1");
    chk("hold_src", eng_src_addr_o, 32'h1000);
    chk("hold_dst", eng_dst_addr_o, 32'h8000);
    chk("hold_len", eng_len_o, 2);
    chk("job1_done_cnt", done_cnt_o, exp_done());
    chk("job1_irq", irq_o, 1);
    chk("job1_busy", busy_o, 0);

    // Fill with engine busy, overflow, then push-while-full with same-cycle pop.
    clr_irq();
    chk("clr_irq", irq_o, 0);
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++)
      push(32'h2000 + 32'(i * 16), 32'h9000 + 32'(i * 16), 25'(i + 1), 1'b1);
    push(32'h2F00, 32'h9F00, 25'd7, 1'b0);
    chk("fill_full", full_o, 1);
    chk("fill_pend", pend_cnt_o, 4);
    chk("fill_ovf", ovf_o, 1);
    clr_irq();
    chk("ovf_cleared", ovf_o, 0);
    chk("ovf_clr_pend", pend_cnt_o, 4);
    force_busy = 1'b0;
    push(32'h3F00, 32'hAF00, 25'd3, 1'b0);
    chk("pushpop_full_pend", pend_cnt_o, 3);
    chk("pushpop_full_ovf", ovf_o, 1);
    wait_idle("fill");
    chk("fill_done_cnt", done_cnt_o, exp_done());

    // Zero-length job; irq set beats same-cycle clear.
    clr_irq();
    chk("clr_irq2", irq_o, 0);
    chk("clr_ovf2", ovf_o, 0);
    push(32'h4000, 32'hB000, 25'd0, 1'b1);
    irq_clr_i = 1'b1;
    chk("zl_busy_pop", busy_o, 0);
    tick();
    irq_clr_i = 1'b0;
    chk("irq_set_beats_clr", irq_o, 1);
    chk("zl_busy_after", busy_o, 0);
    chk("zl_done_cnt", done_cnt_o, exp_done());

    // Completion with interrupts disabled leaves irq low.
    irq_en_i = 1'b0;
    clr_irq();
    push(32'h4100, 32'hB100, 25'd0, 1'b1);
    tick();
    chk("irq_disabled", irq_o, 0);
    chk("irq_dis_done_cnt", done_cnt_o, exp_done());
    irq_en_i = 1'b1;

    // Flush while the first of three jobs is in flight.
    s_before = n_starts;
    push(32'h5000, 32'hC000, 25'd5, 1'b1);
    push(32'h5100, 32'hC100, 25'd3, 1'b1);
    push(32'h5200, 32'hC200, 25'd3, 1'b1);
    wait_done_low("flush");
    chk("flush_busy", busy_o, 1);
    flush_i = 1'b1;
    exp_q.delete();
    tick();
    flush_i = 1'b0;
    chk("flush_pend", pend_cnt_o, 0);
    chk("flush_inflight_busy", busy_o, 1);
    wait_idle("flush");
    chk("flush_starts", n_starts - s_before, 1);
    chk("flush_done_cnt", done_cnt_o, exp_done());

    // Reset in the middle of a job.
    push(32'h6000, 32'hD000, 25'd6, 1'b1);
    wait_done_low("rstjob");
    chk("rstjob_busy", busy_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    done_base = zl_cnt + n_starts;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_pend", pend_cnt_o, 0);
    chk("mid_rst_full", full_o, 0);
    chk("mid_rst_done_cnt", done_cnt_o, 0);
    chk("mid_rst_irq", irq_o, 0);
    chk("mid_rst_ovf", ovf_o, 0);
    chk("mid_rst_start", eng_start_o, 0);
    chk("mid_rst_src", eng_src_addr_o, 0);
    chk("mid_rst_dst", eng_dst_addr_o, 0);
    chk("mid_rst_len", eng_len_o, 0);

    // 256 completions wrap the counter.
    for (int i = 0; i < 255; i++)
      push(32'h7000 + 32'(i), 32'hE000 + 32'(i), 25'd0, 1'b1);
    wait_idle("wrap255");
    chk("done_cnt_255", done_cnt_o, 8'd255);
    push(32'h7FFF, 32'hEFFF, 25'd0, 1'b1);
    wait_idle("wrap256");
    chk("done_cnt_wrap", done_cnt_o, 8'd0);
    chk("done_cnt_model", done_cnt_o, exp_done());

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
